// File: rtl/step_sequencer.sv
// step_sequencer
//   Move-command sequencer for the stepper phase driver. Accepts a move
//   (step count + direction) on a valid/ready handshake. It holds en/dir
//   stable for the whole move and paces it at one step every CLK_DIV
//   cycles. It keeps a wrapping two's-complement position count.
//
// Ports
//   clk        clock
//   rst        asynchronous active-high reset
//   cmd_valid  command presented
//   cmd_ready  command can be accepted (IDLE only)
//   cmd_dir    0 = forward (+1), 1 = reverse (-1)
//   cmd_steps  number of steps in the move
//   abort      terminate the current move (ignored in IDLE)
//   en, busy   high for the whole RUN state
//   dir        direction of the current/last move
//   step_tick  one-cycle pulse per executed step
//   done       one-cycle pulse after every accepted command finishes
//   aborted    last finished move ended by abort
//   position   signed step position, wraps modulo 2^POS_W
module step_sequencer #(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = 8,
  parameter int POS_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             abort,
  output logic             en,
  output logic             dir,
  output logic             step_tick,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [POS_W-1:0] position
);

  localparam int PER_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(CLK_DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic               dir_q, dir_d;
  logic [CNT_W-1:0]   remain_q, remain_d;
  logic [PER_W-1:0]   period_q, period_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;

  // Abort wins over a coincident tick, so the tick is masked here and the
  // step is neither counted nor applied to position.
  assign step_tick = (state_q == RUN) && (period_q == PER_LAST) && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      dir_q     <= 1'b0;
      remain_q  <= '0;
      period_q  <= '0;
      pos_q     <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      remain_q  <= remain_d;
      period_q  <= period_d;
      pos_q     <= pos_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    remain_d  = remain_q;
    period_d  = period_q;
    pos_d     = pos_q;
    done_d    = 1'b0;
    aborted_d = aborted_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          dir_d     = cmd_dir;
          remain_d  = cmd_steps;
          aborted_d = 1'b0;
          period_d  = '0;
          // A zero-step move never enters RUN; it just reports done.
          if (cmd_steps != '0) state_d = RUN;
          else                 done_d  = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else begin
          period_d = (period_q == PER_LAST) ? '0 : period_q + PER_W'(1);
          if (step_tick) begin
            remain_d = remain_q - CNT_W'(1);
            pos_d    = dir_q ? pos_q - POS_W'(1) : pos_q + POS_W'(1);
            if (remain_q == CNT_W'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign en        = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign dir       = dir_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign position  = pos_q;

endmodule

// File: tb/tb_step_sequencer.sv
module tb_step_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_dir = 1'b0;
  logic [7:0]  cmd_steps = 8'd0;
  logic        abort = 1'b0;
  logic        en, dir, step_tick, busy, done, aborted;
  logic [15:0] position;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  step_sequencer #(.CLK_DIV(4), .CNT_W(8), .POS_W(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .abort(abort),
    .en(en), .dir(dir), .step_tick(step_tick), .busy(busy),
    .done(done), .aborted(aborted), .position(position)
  );

  typedef struct {
    logic        v;
    logic        d;
    logic [7:0]  s;
    logic        a;
    logic        en;
    logic        tk;
    logic        dn;
    logic        ab;
    logic        dr;
    logic        rdy;
    logic [15:0] pos;
  } vec_t;

  vec_t tbl[$];

  // {en,busy,tick,done,aborted,dir,ready,position}
  function automatic logic [22:0] outs();
    return {en, busy, step_tick, done, aborted, dir, cmd_ready, position};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, d, input logic [7:0] s, input logic a,
                     input logic e, tk, dn, ab, dr, rdy, input logic [15:0] pos);
    vec_t x;
    x.v = v; x.d = d; x.s = s; x.a = a;
    x.en = e; x.tk = tk; x.dn = dn; x.ab = ab; x.dr = dr; x.rdy = rdy; x.pos = pos;
    tbl.push_back(x);
  endtask

  // RUN cycles 1..n*4 of a normal move, then its done cycle, which may
  // carry the next command (back-to-back acceptance).
  task automatic add_move(input int n, input logic d, input int p0,
                          input logic nv, nd, input logic [7:0] ns);
    for (int c = 1; c <= n * 4; c++) begin
      int k = (c - 1) / 4;
      add(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, (c % 4) == 0, 1'b0, 1'b0, d, 1'b0,
          16'(p0 + (d ? -k : k)));
    end
    add(nv, nd, ns, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, d, 1'b1, 16'(p0 + (d ? -n : n)));
  endtask

  task automatic tick_clk();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end by 200000");
    $fatal(1);
  end

  initial begin
    // ---- build vector table ----
    add(1'b1, 1'b0, 8'd3, 1'b0, 0, 0, 0, 0, 0, 1, 16'h0000);  // accept fwd 3
    add_move(3, 1'b0, 0, 1'b1, 1'b1, 8'd2);                    // -> 3, accept rev 2
    add_move(2, 1'b1, 3, 1'b1, 1'b1, 8'd5);                    // -> 1, accept rev 5
    add_move(5, 1'b1, 1, 1'b1, 1'b0, 8'd0);                    // -> 0xFFFC, zero-step
    add(1'b0, 1'b0, 8'd0, 1'b1, 0, 0, 1, 0, 0, 1, 16'hFFFC);  // zero-step done, abort idle
    add(1'b0, 1'b0, 8'd0, 1'b1, 0, 0, 0, 0, 0, 1, 16'hFFFC);  // abort in idle: no effect
    add(1'b1, 1'b0, 8'd10, 1'b0, 0, 0, 0, 0, 0, 1, 16'hFFFC); // accept fwd 10
    for (int c = 1; c <= 7; c++)                                // held cmd ignored
      add(1'b1, 1'b1, 8'd7, 1'b0, 1, c == 4, 0, 0, 0, 0, (c <= 4) ? 16'hFFFC : 16'hFFFD);
    add(1'b1, 1'b1, 8'd7, 1'b1, 1, 0, 0, 0, 0, 0, 16'hFFFD);  // abort on tick cycle
    add(1'b1, 1'b1, 8'd7, 1'b0, 0, 0, 1, 1, 0, 1, 16'hFFFD);  // done+aborted, accept held
    add(1'b0, 1'b0, 8'd0, 1'b1, 1, 0, 0, 0, 1, 0, 16'hFFFD);  // RUN, aborted cleared, abort
    add(1'b0, 1'b0, 8'd0, 1'b0, 0, 0, 1, 1, 1, 1, 16'hFFFD);  // done+aborted

    // ---- reset at start ----
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", outs(), {7'b0000001, 16'h0000});
    rst = 1'b0;
    #1;
    chk("ready_after_release", cmd_ready, 1'b1);
    tick_clk();

    // ---- table ----
    foreach (tbl[i]) begin
      cmd_valid = tbl[i].v; cmd_dir = tbl[i].d; cmd_steps = tbl[i].s; abort = tbl[i].a;
      #1;
      n_vec++;
      if (outs() !== {tbl[i].en, tbl[i].en, tbl[i].tk, tbl[i].dn, tbl[i].ab,
                      tbl[i].dr, tbl[i].rdy, tbl[i].pos}) begin
        n_bad++;
        $display("FAIL vec%0d: got %b_%h expected %b_%h", i, outs() >> 16, position,
                 {tbl[i].en, tbl[i].en, tbl[i].tk, tbl[i].dn, tbl[i].ab, tbl[i].dr, tbl[i].rdy},
                 tbl[i].pos);
      end
      tick_clk();
    end
    cmd_valid = 1'b0; abort = 1'b0; cmd_steps = 8'd0; cmd_dir = 1'b0;

    // ---- asynchronous reset between edges (pos/dir/aborted nonzero) ----
    #3 rst = 1'b1;
    #1 chk("async_reset_idle", outs(), {7'b0000001, 16'h0000});
    tick_clk();
    chk("reset_held", outs(), {7'b0000001, 16'h0000});
    rst = 1'b0;
    tick_clk();

    // ---- reset mid-move ----
    cmd_valid = 1'b1; cmd_steps = 8'd5; cmd_dir = 1'b0;
    tick_clk();                        // cycle 1
    cmd_valid = 1'b0;
    repeat (5) tick_clk();             // cycle 6
    chk("midmove_pos_before", {en, position}, {1'b1, 16'h0001});
    #3 rst = 1'b1;
    #1 chk("midmove_reset", {en, busy, done, position}, {3'b000, 16'h0000});
    tick_clk();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("no_done_after_reset", {done, en, cmd_ready}, 3'b001);
      tick_clk();
    end

    // ---- fresh single-step move ----
    cmd_valid = 1'b1; cmd_steps = 8'd1; cmd_dir = 1'b0;
    tick_clk();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("one_step_c%0d", c), {en, step_tick, done}, {1'b1, c == 4, 1'b0});
      tick_clk();
    end
    chk("one_step_done", {en, done, aborted, cmd_ready, position}, {4'b0101, 16'h0001});
    tick_clk();
    chk("one_step_after", {done, en}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
